// File: rtl/gpio_input_debounce.sv
// Per-bit input conditioner: synchroniser, stability-counter debounce, edge strobes, sticky events.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from a stable pin change; free-running, no backpressure.
// GPIO_DEBOUNCE_EVENT_EN builds evt_pending/irq; when undefined both are tied low.
module gpio_input_debounce #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] evt_clear,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] evt_pending,
  output logic             irq
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]                  clean_q, clean_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;

  always_comb begin
    sync_d[0] = raw_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Any sample that agrees with the accepted level restarts the count, so glitches never accumulate.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]   = '0;
        clean_d[i] = s[i];
        rise_d[i]  = s[i];
        fall_d[i]  = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_out  = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

`ifdef GPIO_DEBOUNCE_EVENT_EN
  logic [WIDTH-1:0] pend_q, pend_d;

  // Set terms are OR-ed after the clear mask so a same-cycle set beats the clear.
  always_comb begin
    pend_d = (pend_q & ~evt_clear) | (rise_d & rise_en) | (fall_d & fall_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign evt_pending = pend_q;
  assign irq         = |pend_q;
`else
  logic unused_evt_inputs;
  assign unused_evt_inputs = ^{rise_en, fall_en, evt_clear};
  assign evt_pending       = '0;
  assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Directed bench for gpio_input_debounce at WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_gpio_input_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw_in, rise_en, fall_en, evt_clear;
  logic [3:0] clean_out, rise_pulse, fall_pulse, evt_pending;
  logic       irq;

  int n_vec = 0;
  int n_err = 0;

  gpio_input_debounce #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .rise_en(rise_en), .fall_en(fall_en),
    .evt_clear(evt_clear), .clean_out(clean_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .evt_pending(evt_pending), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pending value depends on whether the event block is built.
  function automatic logic [3:0] ev(input logic [3:0] x);
`ifdef GPIO_DEBOUNCE_EVENT_EN
    return x;
`else
    return 4'b0000 & x;
`endif
  endfunction

  task automatic chk_evt(input string tag, input logic [3:0] pend);
    chk({tag, "_pend"}, evt_pending, ev(pend));
    chk({tag, "_irq"}, irq, |ev(pend));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; raw_in = '0; rise_en = '0; fall_en = '0; evt_clear = '0;
    repeat (3) tick();
    chk("rst_clean", clean_out, 4'b0000);
    chk("rst_rise", rise_pulse, 4'b0000);
    chk("rst_fall", fall_pulse, 4'b0000);
    chk("rst_pend", evt_pending, 4'b0000);
    chk("rst_irq", irq, 1'b0);

    // Clean step on bit 0: update exactly at edge 6.
    rst_n  = 1'b1;
    raw_in = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk("step_clean", clean_out, (e >= 6) ? 4'b0001 : 4'b0000);
      chk("step_rise", rise_pulse, (e == 6) ? 4'b0001 : 4'b0000);
      chk("step_fall", fall_pulse, 4'b0000);
    end

    // Three-cycle glitch on bit 1 is rejected.
    raw_in = 4'b0011;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("gl3_clean", clean_out, 4'b0001);
      chk("gl3_rise", rise_pulse, 4'b0000);
      if (e == 3) raw_in = 4'b0001;
    end

    // Four-cycle pulse is accepted, then falls four cycles after the low level is synchronised.
    raw_in = 4'b0011;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("gl4_clean", clean_out, (e >= 6 && e < 10) ? 4'b0011 : 4'b0001);
      chk("gl4_rise", rise_pulse, (e == 6) ? 4'b0010 : 4'b0000);
      chk("gl4_fall", fall_pulse, (e == 10) ? 4'b0010 : 4'b0000);
      if (e == 4) raw_in = 4'b0001;
    end

    // Events: rise enabled on bit 2 only.
    rise_en = 4'b0100;
    raw_in  = 4'b0101;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk("evr_clean", clean_out, (e >= 6) ? 4'b0101 : 4'b0001);
      chk("evr_rise", rise_pulse, (e == 6) ? 4'b0100 : 4'b0000);
      chk_evt("evr", (e >= 6) ? 4'b0100 : 4'b0000);
    end
    raw_in = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk("evf_clean", clean_out, (e >= 6) ? 4'b0001 : 4'b0101);
      chk("evf_fall", fall_pulse, (e == 6) ? 4'b0100 : 4'b0000);
      chk_evt("evf", 4'b0100);
    end
    evt_clear = 4'b0100;
    tick();
    evt_clear = 4'b0000;
    chk_evt("evclr", 4'b0000);

    // Clear strobe coincides with a new enabled rise: set must win.
    raw_in = 4'b0101;
    for (int e = 1; e <= 6; e++) begin
      if (e == 6) evt_clear = 4'b0100;
      tick();
      evt_clear = 4'b0000;
      chk("col_rise", rise_pulse, (e == 6) ? 4'b0100 : 4'b0000);
      chk_evt("col", (e == 6) ? 4'b0100 : 4'b0000);
    end
    rise_en = 4'b0000;
    tick();
    chk_evt("en_drop", 4'b0100);
    rise_en = 4'b0100;

    // Reset mid-count, then power-on style rise on all bits.
    raw_in = 4'b1111;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_clean", clean_out, 4'b0000);
    chk("mid_rst_rise", rise_pulse, 4'b0000);
    chk_evt("mid_rst", 4'b0000);
    #1 rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk("por_clean", clean_out, (e >= 6) ? 4'b1111 : 4'b0000);
      chk("por_rise", rise_pulse, (e == 6) ? 4'b1111 : 4'b0000);
      chk("por_fall", fall_pulse, 4'b0000);
      chk_evt("por", (e >= 6) ? 4'b0100 : 4'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
